// File: rtl/pipe_ldm_seq_if.sv
// Bundle between the execute stage, register file, data memory and the LDM/STM sequencer.
interface pipe_ldm_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             is_load;
  logic [15:0]      reglist;
  logic [1:0]       pu;
  logic             wback;
  logic [3:0]       rn;
  logic [WIDTH-1:0] base;
  logic             busy;
  logic             done;
  logic [3:0]       ra;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             rf_we;
  logic [3:0]       rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic             pc_load;

  // Pipeline / register file / memory side.
  modport master (
    output start, is_load, reglist, pu, wback, rn, base, rd, mem_rdata,
    input  busy, done, ra, mem_addr, mem_we, mem_wdata, rf_we, rf_wa, rf_wd, pc_load
  );

  // Sequencer side.
  modport slave (
    input  start, is_load, reglist, pu, wback, rn, base, rd, mem_rdata,
    output busy, done, ra, mem_addr, mem_we, mem_wdata, rf_we, rf_wa, rf_wd, pc_load
  );
endinterface

// File: rtl/pipe_ldm_seq.sv
// LDM/STM block-transfer sequencer: stalls the pipe and moves one register per cycle,
// then optionally writes back the base register.
module pipe_ldm_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic          i_clk,
  input logic          i_reset,
  pipe_ldm_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StXfer, StWb} state_e;

  state_e           r_state, w_state_nxt;
  logic [15:0]      r_mask, w_mask_nxt;
  logic [WIDTH-1:0] r_addr, w_addr_nxt;
  logic [WIDTH-1:0] r_wbval, w_wbval_nxt;
  logic             r_is_load, w_is_load_nxt;
  logic             r_wback, w_wback_nxt;
  logic             r_rn_in, w_rn_in_nxt;
  logic [3:0]       r_rn, w_rn_nxt;
  logic             r_done, w_done_nxt;

  logic [4:0]       w_cnt;
  logic [WIDTH-1:0] w_n4;
  logic [WIDTH-1:0] w_start_addr;
  logic [3:0]       w_cur;
  logic [15:0]      w_mask_left;

  logic             w_busy, w_mem_we, w_rf_we, w_pc_load;
  logic [3:0]       w_ra, w_rf_wa;
  logic [WIDTH-1:0] w_mem_addr, w_mem_wdata, w_rf_wd;

  // Popcount of the incoming list, start address per addressing mode, and lowest set mask bit.
  always_comb begin
    w_cnt = 5'd0;
    for (int i = 0; i < 16; i++) w_cnt = w_cnt + 5'(bus.reglist[i]);
    w_n4 = WIDTH'({w_cnt, 2'b00});
    unique case (bus.pu)
      2'b01:   w_start_addr = bus.base;
      2'b11:   w_start_addr = bus.base + WIDTH'(4);
      2'b00:   w_start_addr = bus.base - w_n4 + WIDTH'(4);
      default: w_start_addr = bus.base - w_n4;
    endcase
    w_cur = 4'd0;
    for (int i = 15; i >= 0; i--) if (r_mask[i]) w_cur = 4'(i);
    w_mask_left = r_mask & ~(16'd1 << w_cur);
  end

  // Next-state and output decode; reset forces every output low in the same cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_mask_nxt    = r_mask;
    w_addr_nxt    = r_addr;
    w_wbval_nxt   = r_wbval;
    w_is_load_nxt = r_is_load;
    w_wback_nxt   = r_wback;
    w_rn_in_nxt   = r_rn_in;
    w_rn_nxt      = r_rn;
    w_done_nxt    = 1'b0;
    w_busy        = 1'b0;
    w_mem_we      = 1'b0;
    w_rf_we       = 1'b0;
    w_pc_load     = 1'b0;
    w_ra          = 4'd0;
    w_rf_wa       = 4'd0;
    w_mem_addr    = '0;
    w_mem_wdata   = '0;
    w_rf_wd       = '0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          if (w_cnt != 5'd0) begin
            w_state_nxt   = StXfer;
            w_mask_nxt    = bus.reglist;
            w_addr_nxt    = w_start_addr;
            w_wbval_nxt   = bus.pu[0] ? bus.base + w_n4 : bus.base - w_n4;
            w_is_load_nxt = bus.is_load;
            w_wback_nxt   = bus.wback;
            w_rn_in_nxt   = bus.reglist[bus.rn];
            w_rn_nxt      = bus.rn;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      StXfer: begin
        w_busy     = 1'b1;
        w_mem_addr = r_addr;
        if (!r_is_load) begin
          w_ra        = w_cur;
          w_mem_we    = 1'b1;
          w_mem_wdata = bus.rd;
        end else if (w_cur == 4'd15) begin
          w_pc_load = 1'b1;
          w_rf_wd   = bus.mem_rdata;
        end else begin
          w_rf_we = 1'b1;
          w_rf_wa = w_cur;
          w_rf_wd = bus.mem_rdata;
        end
        w_mask_nxt = w_mask_left;
        w_addr_nxt = r_addr + WIDTH'(4);
        if (w_mask_left == 16'd0) begin
          // A load that reloads the base keeps the loaded value, so WB is skipped.
          if (r_wback && (!r_is_load || !r_rn_in)) begin
            w_state_nxt = StWb;
          end else begin
            w_state_nxt = StIdle;
            w_done_nxt  = 1'b1;
          end
        end
      end
      StWb: begin
        w_busy      = 1'b1;
        w_rf_we     = 1'b1;
        w_rf_wa     = r_rn;
        w_rf_wd     = r_wbval;
        w_state_nxt = StIdle;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = StIdle;
    endcase
    if (i_reset) begin
      w_busy      = 1'b0;
      w_mem_we    = 1'b0;
      w_rf_we     = 1'b0;
      w_pc_load   = 1'b0;
      w_ra        = 4'd0;
      w_rf_wa     = 4'd0;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_rf_wd     = '0;
    end
  end

  // State and latched-operand registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_mask    <= 16'd0;
      r_addr    <= '0;
      r_wbval   <= '0;
      r_is_load <= 1'b0;
      r_wback   <= 1'b0;
      r_rn_in   <= 1'b0;
      r_rn      <= 4'd0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_addr    <= w_addr_nxt;
      r_wbval   <= w_wbval_nxt;
      r_is_load <= w_is_load_nxt;
      r_wback   <= w_wback_nxt;
      r_rn_in   <= w_rn_in_nxt;
      r_rn      <= w_rn_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = r_done & ~i_reset;
  assign bus.ra        = w_ra;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = w_mem_wdata;
  assign bus.rf_we     = w_rf_we;
  assign bus.rf_wa     = w_rf_wa;
  assign bus.rf_wd     = w_rf_wd;
  assign bus.pc_load   = w_pc_load;

endmodule
